color_analysis_hls_deadlock_monitor_unit: RTL and testbench

COLOR_ANALYSIS_HLS_DEADLOCK_MONITOR_UNIT -- requirements
Module: color_analysis_hls_deadlock_monitor_unit

---
 rtl/color_analysis_dl_pkg.sv | 16 +
 rtl/color_analysis_hls_deadlock_monitor_unit_if.sv | 27 ++
 rtl/color_analysis_hls_dl_persist_cnt.sv | 37 +++
 rtl/color_analysis_hls_deadlock_monitor_unit.sv | 118 +++++++++++
 tb/tb_color_analysis_hls_deadlock_monitor_unit.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/color_analysis_dl_pkg.sv
// Shared types for the colour-analysis deadlock monitor: FSM state encoding and
// the helper that sizes the persistence counter from the stall threshold.
package color_analysis_dl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    DETECTED = 2'd2,
    HOLD     = 2'd3
  } dl_state_e;

  function automatic int cnt_width(input int thresh);
    return $clog2(thresh + 1);
  endfunction

endpackage

// File: rtl/color_analysis_hls_deadlock_monitor_unit_if.sv
// Dependence and report-token bus between a dataflow process wrapper and its
// deadlock monitor unit; the monitor sits on the slave side.
interface color_analysis_hls_deadlock_monitor_unit_if #(
  parameter int PROC_NUM     = 4,
  parameter int IN_CHAN_NUM  = 2,
  parameter int OUT_CHAN_NUM = 3
);

  logic [OUT_CHAN_NUM-1:0]         proc_dep_vld_vec;
  logic [IN_CHAN_NUM-1:0]          in_chan_dep_vld_vec;
  logic [IN_CHAN_NUM*PROC_NUM-1:0] in_chan_dep_data_vec;
  logic [IN_CHAN_NUM-1:0]          token_in_vec;
  logic [OUT_CHAN_NUM-1:0]         out_chan_dep_vld_vec;
  logic [PROC_NUM-1:0]             out_chan_dep_data;
  logic [OUT_CHAN_NUM-1:0]         token_out_vec;

  modport master (
    output proc_dep_vld_vec, in_chan_dep_vld_vec, in_chan_dep_data_vec, token_in_vec,
    input  out_chan_dep_vld_vec, out_chan_dep_data, token_out_vec
  );

  modport slave (
    input  proc_dep_vld_vec, in_chan_dep_vld_vec, in_chan_dep_data_vec, token_in_vec,
    output out_chan_dep_vld_vec, out_chan_dep_data, token_out_vec
  );

endinterface

// File: rtl/color_analysis_hls_dl_persist_cnt.sv
// Saturating persistence counter: counts consecutive candidate cycles and flags
// the cycle on which the count is about to reach the stall threshold.
module color_analysis_hls_dl_persist_cnt
  import color_analysis_dl_pkg::*;
#(
  parameter int STALL_THRESH = 16,
  localparam int CW = cnt_width(STALL_THRESH)
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic candidate,
  output logic reach
);

  localparam logic [CW-1:0] THRESH = CW'(STALL_THRESH);

  logic [CW-1:0] count;
  logic [CW-1:0] count_next;

  always_comb begin
    count_next = '0;
    if (candidate) begin
      count_next = (count == THRESH) ? THRESH : count + CW'(1);
    end
    reach = candidate && (count_next == THRESH);
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/color_analysis_hls_deadlock_monitor_unit.sv
// Per-process deadlock monitor: merges dependence vectors, declares a deadlock
// after a persistent self-dependence. Define COLOR_ANALYSIS_DL_STATS_EN for stall_cycles.
module color_analysis_hls_deadlock_monitor_unit
  import color_analysis_dl_pkg::*;
#(
  parameter int PROC_NUM     = 4,
  parameter int PROC_ID      = 0,
  parameter int IN_CHAN_NUM  = 2,
  parameter int OUT_CHAN_NUM = 3,
  parameter int STALL_THRESH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  color_analysis_hls_deadlock_monitor_unit_if.slave bus,
  input  logic                 dl_detect_in,
  input  logic                 origin,
  input  logic                 token_clear,
  input  logic                 dl_clear,
  output logic                 dl_detect_out,
  output logic                 dl_sticky,
  output logic [PROC_NUM-1:0]  dl_dep_snapshot
`ifdef COLOR_ANALYSIS_DL_STATS_EN
  ,
  output logic [31:0]          stall_cycles
`endif
);

  localparam logic [PROC_NUM-1:0] PROC_ONEHOT = PROC_NUM'(1) << PROC_ID;

  dl_state_e           state;
  dl_state_e           state_next;
  logic [PROC_NUM-1:0] dep_comb;
  logic [PROC_NUM-1:0] dep;
  logic [PROC_NUM-1:0] dep_reg;
  logic                gate;
  logic                any_blocked;
  logic                candidate;
  logic                reach;

  always_comb begin
    dep_comb = '0;
    for (int i = 0; i < IN_CHAN_NUM; i++) begin
      dep_comb = dep_comb | (bus.in_chan_dep_data_vec[i*PROC_NUM +: PROC_NUM]
                             & {PROC_NUM{bus.in_chan_dep_vld_vec[i]}});
    end
  end

  // Once a deadlock is known globally, only a passing token may refresh dep.
  assign any_blocked = |bus.proc_dep_vld_vec;
  assign gate        = ~dl_detect_in | (|bus.token_in_vec);
  assign dep         = gate ? dep_comb : dep_reg;
  assign candidate   = gate & dep[PROC_ID] & any_blocked;

  assign bus.out_chan_dep_vld_vec = bus.proc_dep_vld_vec;
  assign bus.out_chan_dep_data    = dep_reg | PROC_ONEHOT;

  color_analysis_hls_dl_persist_cnt #(
    .STALL_THRESH (STALL_THRESH)
  ) u_persist_cnt (
    .clock     (clock),
    .reset     (reset),
    .clear     (dl_clear),
    .candidate (candidate),
    .reach     (reach)
  );

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, ARMED: begin
        if (reach)          state_next = DETECTED;
        else if (candidate) state_next = ARMED;
        else                state_next = IDLE;
      end
      DETECTED: state_next = HOLD;
      HOLD:     state_next = HOLD;
      default:  state_next = IDLE;
    endcase
    if (dl_clear) state_next = IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      dep_reg         <= '0;
      dl_dep_snapshot <= '0;
      bus.token_out_vec <= '0;
    end else begin
      state   <= state_next;
      dep_reg <= any_blocked ? dep : '0;
      if (dl_clear) begin
        dl_dep_snapshot <= '0;
      end else if (state_next == DETECTED) begin
        dl_dep_snapshot <= dep;
      end
      // origin starts a report even when forwarding is being suppressed.
      if (origin || ((|bus.token_in_vec) && !token_clear)) begin
        bus.token_out_vec <= bus.proc_dep_vld_vec;
      end else begin
        bus.token_out_vec <= '0;
      end
    end
  end

  assign dl_detect_out = (state == DETECTED);
  assign dl_sticky     = (state == DETECTED) || (state == HOLD);

`ifdef COLOR_ANALYSIS_DL_STATS_EN
  always_ff @(posedge clock) begin
    if (reset || dl_clear) begin
      stall_cycles <= '0;
    end else if (any_blocked && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_color_analysis_hls_deadlock_monitor_unit.sv
// Directed bench for the deadlock monitor: a cycle-by-cycle vector table on a
// STALL_THRESH=4 / PROC_ID=0 unit plus hand sequences for reset and a THRESH=1 unit.
module tb_color_analysis_hls_deadlock_monitor_unit;

  typedef struct {
    logic [2:0] pvld;
    logic [1:0] vld;
    logic [7:0] data;
    logic [1:0] tin;
    logic       dl_in;
    logic       org;
    logic       tclr;
    logic       dlclr;
    logic [3:0] exp_odata;
    logic [2:0] exp_tok;
    logic       exp_det;
    logic       exp_stk;
    logic [3:0] exp_snap;
  } vec_t;

  logic       clock;
  logic       reset;
  logic       dl_detect_in, origin, token_clear, dl_clear;
  logic       dl_detect_out, dl_sticky;
  logic [3:0] dl_dep_snapshot;
  logic       dl_detect_in2, origin2, token_clear2, dl_clear2;
  logic       dl_detect_out2, dl_sticky2;
  logic [3:0] dl_dep_snapshot2;
`ifdef COLOR_ANALYSIS_DL_STATS_EN
  logic [31:0] stall_cycles, stall_cycles2;
`endif

  int total = 0;
  int bad   = 0;
  vec_t vecs[$];

  color_analysis_hls_deadlock_monitor_unit_if #(.PROC_NUM(4), .IN_CHAN_NUM(2), .OUT_CHAN_NUM(3)) bus ();
  color_analysis_hls_deadlock_monitor_unit_if #(.PROC_NUM(4), .IN_CHAN_NUM(2), .OUT_CHAN_NUM(3)) bus2 ();

  color_analysis_hls_deadlock_monitor_unit #(
    .PROC_NUM(4), .PROC_ID(0), .IN_CHAN_NUM(2), .OUT_CHAN_NUM(3), .STALL_THRESH(4)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .bus             (bus),
    .dl_detect_in    (dl_detect_in),
    .origin          (origin),
    .token_clear     (token_clear),
    .dl_clear        (dl_clear),
    .dl_detect_out   (dl_detect_out),
    .dl_sticky       (dl_sticky),
    .dl_dep_snapshot (dl_dep_snapshot)
`ifdef COLOR_ANALYSIS_DL_STATS_EN
    ,
    .stall_cycles    (stall_cycles)
`endif
  );

  color_analysis_hls_deadlock_monitor_unit #(
    .PROC_NUM(4), .PROC_ID(2), .IN_CHAN_NUM(2), .OUT_CHAN_NUM(3), .STALL_THRESH(1)
  ) dut2 (
    .clock           (clock),
    .reset           (reset),
    .bus             (bus2),
    .dl_detect_in    (dl_detect_in2),
    .origin          (origin2),
    .token_clear     (token_clear2),
    .dl_clear        (dl_clear2),
    .dl_detect_out   (dl_detect_out2),
    .dl_sticky       (dl_sticky2),
    .dl_dep_snapshot (dl_dep_snapshot2)
`ifdef COLOR_ANALYSIS_DL_STATS_EN
    ,
    .stall_cycles    (stall_cycles2)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic vec_t mk(logic [2:0] pvld, logic [1:0] vld, logic [7:0] data,
                              logic [1:0] tin, logic dl_in, logic org, logic tclr,
                              logic dlclr, logic [3:0] eod, logic [2:0] etok,
                              logic edet, logic estk, logic [3:0] esnap);
    vec_t v;
    v.pvld = pvld; v.vld = vld; v.data = data; v.tin = tin;
    v.dl_in = dl_in; v.org = org; v.tclr = tclr; v.dlclr = dlclr;
    v.exp_odata = eod; v.exp_tok = etok; v.exp_det = edet;
    v.exp_stk = estk; v.exp_snap = esnap;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    bus.proc_dep_vld_vec     = v.pvld;
    bus.in_chan_dep_vld_vec  = v.vld;
    bus.in_chan_dep_data_vec = v.data;
    bus.token_in_vec         = v.tin;
    dl_detect_in             = v.dl_in;
    origin                   = v.org;
    token_clear              = v.tclr;
    dl_clear                 = v.dlclr;
  endtask

  task automatic applyStimulus2(input logic [2:0] pvld, input logic [1:0] vld,
                                input logic [7:0] data, input logic dlclr);
    bus2.proc_dep_vld_vec     = pvld;
    bus2.in_chan_dep_vld_vec  = vld;
    bus2.in_chan_dep_data_vec = data;
    bus2.token_in_vec         = 2'b00;
    dl_detect_in2             = 1'b0;
    origin2                   = 1'b0;
    token_clear2              = 1'b0;
    dl_clear2                 = dlclr;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Stall pattern: chan0 carries a self-dependence, output channel 0 blocked.
  function automatic vec_t stall(logic org, logic dlclr, logic [2:0] etok,
                                 logic edet, logic estk, logic [3:0] esnap);
    return mk(3'b001, 2'b01, 8'h01, 2'b00, 1'b0, org, 1'b0, dlclr,
              4'b0001, etok, edet, estk, esnap);
  endfunction

  function automatic vec_t idle(logic dlclr, logic [3:0] eod, logic estk, logic [3:0] esnap);
    return mk(3'b000, 2'b00, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, dlclr,
              eod, 3'b000, 1'b0, estk, esnap);
  endfunction

  initial begin
    reset = 1'b1;
    applyStimulus(idle(1'b0, 4'b0001, 1'b0, 4'b0000));
    applyStimulus2(3'b000, 2'b00, 8'h00, 1'b0);

    // threshold hit, then hold, then clear
    for (int k = 0; k < 3; k++) vecs.push_back(stall(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 4'b0000));
    vecs.push_back(stall(1'b0, 1'b0, 3'b000, 1'b1, 1'b1, 4'b0001));
    vecs.push_back(stall(1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 4'b0001));
    vecs.push_back(idle(1'b0, 4'b0001, 1'b1, 4'b0001));
    vecs.push_back(idle(1'b1, 4'b0001, 1'b0, 4'b0000));
    // short stall must not count toward the next one
    for (int k = 0; k < 3; k++) vecs.push_back(stall(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 4'b0000));
    vecs.push_back(idle(1'b0, 4'b0001, 1'b0, 4'b0000));
    for (int k = 0; k < 3; k++) vecs.push_back(stall(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 4'b0000));
    vecs.push_back(stall(1'b0, 1'b0, 3'b000, 1'b1, 1'b1, 4'b0001));
    vecs.push_back(stall(1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 4'b0001));
    // clear while HOLD with candidate still high, then re-stall to a second pulse
    vecs.push_back(stall(1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 4'b0000));
    for (int k = 0; k < 3; k++) vecs.push_back(stall(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 4'b0000));
    vecs.push_back(stall(1'b0, 1'b0, 3'b000, 1'b1, 1'b1, 4'b0001));
    vecs.push_back(idle(1'b0, 4'b0001, 1'b1, 4'b0001));
    vecs.push_back(idle(1'b1, 4'b0001, 1'b0, 4'b0000));
    // dep freeze under dl_detect_in, invalid chan1 data masked
    vecs.push_back(mk(3'b001, 2'b01, 8'h42, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 3'b000, 1'b0, 1'b0, 4'b0000));
    vecs.push_back(mk(3'b001, 2'b01, 8'h41, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0011, 3'b000, 1'b0, 1'b0, 4'b0000));
    vecs.push_back(mk(3'b001, 2'b01, 8'h41, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0011, 3'b000, 1'b0, 1'b0, 4'b0000));
    vecs.push_back(mk(3'b001, 2'b11, 8'h41, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0011, 3'b001, 1'b0, 1'b0, 4'b0000));
    vecs.push_back(mk(3'b001, 2'b11, 8'h41, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0101, 3'b001, 1'b0, 1'b0, 4'b0000));
    vecs.push_back(mk(3'b001, 2'b11, 8'h41, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0101, 3'b001, 1'b0, 1'b0, 4'b0000));
    vecs.push_back(mk(3'b001, 2'b11, 8'h41, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0101, 3'b001, 1'b1, 1'b1, 4'b0101));
    vecs.push_back(idle(1'b0, 4'b0101, 1'b1, 4'b0101));
    vecs.push_back(idle(1'b1, 4'b0001, 1'b0, 4'b0000));
    // token forwarding: clear suppresses, origin overrides
    vecs.push_back(mk(3'b101, 2'b00, 8'h00, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0001, 3'b000, 1'b0, 1'b0, 4'b0000));
    vecs.push_back(mk(3'b101, 2'b00, 8'h00, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0001, 3'b101, 1'b0, 1'b0, 4'b0000));
    vecs.push_back(mk(3'b110, 2'b00, 8'h00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 3'b110, 1'b0, 1'b0, 4'b0000));
    vecs.push_back(mk(3'b011, 2'b00, 8'h00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0001, 3'b011, 1'b0, 1'b0, 4'b0000));
    vecs.push_back(idle(1'b0, 4'b0001, 1'b0, 4'b0000));

    repeat (2) @(posedge clock);
    #1;
    checkOutput("rst.det", 32'(dl_detect_out), 32'd0);
    checkOutput("rst.stk", 32'(dl_sticky), 32'd0);
    checkOutput("rst.snap", 32'(dl_dep_snapshot), 32'd0);
    checkOutput("rst.tok", 32'(bus.token_out_vec), 32'd0);
    checkOutput("rst.odata", 32'(bus.out_chan_dep_data), 32'h1);
    checkOutput("rst.odata2", 32'(bus2.out_chan_dep_data), 32'h4);
    @(negedge clock);
    reset = 1'b0;

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clock);
      applyStimulus(vecs[k]);
      #1;
      checkOutput($sformatf("v%0d.odata", k), 32'(bus.out_chan_dep_data), 32'(vecs[k].exp_odata));
      checkOutput($sformatf("v%0d.ovld", k), 32'(bus.out_chan_dep_vld_vec), 32'(vecs[k].pvld));
      @(posedge clock);
      #1;
      checkOutput($sformatf("v%0d.tok", k), 32'(bus.token_out_vec), 32'(vecs[k].exp_tok));
      checkOutput($sformatf("v%0d.det", k), 32'(dl_detect_out), 32'(vecs[k].exp_det));
      checkOutput($sformatf("v%0d.stk", k), 32'(dl_sticky), 32'(vecs[k].exp_stk));
      checkOutput($sformatf("v%0d.snap", k), 32'(dl_dep_snapshot), 32'(vecs[k].exp_snap));
    end

    // reset in ARMED with count 3 discards progress
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      applyStimulus(stall(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 4'b0000));
      @(posedge clock);
      #1;
      checkOutput($sformatf("arm%0d.tok", k), 32'(bus.token_out_vec), 32'h1);
      checkOutput($sformatf("arm%0d.det", k), 32'(dl_detect_out), 32'd0);
    end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("rstarm.tok", 32'(bus.token_out_vec), 32'd0);
    checkOutput("rstarm.det", 32'(dl_detect_out), 32'd0);
    checkOutput("rstarm.stk", 32'(dl_sticky), 32'd0);
    checkOutput("rstarm.odata", 32'(bus.out_chan_dep_data), 32'h1);
`ifdef COLOR_ANALYSIS_DL_STATS_EN
    checkOutput("rstarm.stall", stall_cycles, 32'd0);
`endif
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(stall(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 4'b0000));
    for (int k = 0; k < 4; k++) begin
      @(posedge clock);
      #1;
      checkOutput($sformatf("rearm%0d.det", k), 32'(dl_detect_out), (k == 3) ? 32'd1 : 32'd0);
    end
    checkOutput("rearm.snap", 32'(dl_dep_snapshot), 32'h1);
    @(posedge clock);
    #1;
    checkOutput("hold.stk", 32'(dl_sticky), 32'd1);
    // reset in HOLD zeroes sticky state
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("rsthold.stk", 32'(dl_sticky), 32'd0);
    checkOutput("rsthold.snap", 32'(dl_dep_snapshot), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(idle(1'b0, 4'b0001, 1'b0, 4'b0000));

    // THRESH=1 unit owning bit 2: a dependence without bit 2 is not a candidate
    @(negedge clock);
    applyStimulus2(3'b010, 2'b10, 8'h10, 1'b0);
    @(posedge clock);
    #1;
    checkOutput("t1.nocand.det", 32'(dl_detect_out2), 32'd0);
    @(negedge clock);
    applyStimulus2(3'b010, 2'b10, 8'h50, 1'b0);
    @(posedge clock);
    #1;
    checkOutput("t1.det", 32'(dl_detect_out2), 32'd1);
    checkOutput("t1.stk", 32'(dl_sticky2), 32'd1);
    checkOutput("t1.snap", 32'(dl_dep_snapshot2), 32'h5);
    checkOutput("t1.odata", 32'(bus2.out_chan_dep_data), 32'h5);
    @(posedge clock);
    #1;
    checkOutput("t1.hold.det", 32'(dl_detect_out2), 32'd0);
    checkOutput("t1.hold.stk", 32'(dl_sticky2), 32'd1);
    @(negedge clock);
    applyStimulus2(3'b000, 2'b00, 8'h00, 1'b1);
    @(posedge clock);
    #1;
    checkOutput("t1.clr.stk", 32'(dl_sticky2), 32'd0);
    checkOutput("t1.clr.snap", 32'(dl_dep_snapshot2), 32'd0);
    @(negedge clock);
    applyStimulus2(3'b000, 2'b00, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
